// File: rtl/vgalcd_fetch_ctrl_if.sv
// Burst read-request port between the fetch scheduler and the bus master.
// A request is accepted on the cycle where req_o && gnt_i.
interface vgalcd_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_o;
  logic                  gnt_i;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic [LEN_WIDTH-1:0]  req_len_o;

  modport master (output req_o, req_addr_o, req_len_o, input gnt_i);
  modport slave  (input req_o, req_addr_o, req_len_o, output gnt_i);
endinterface

// File: rtl/vgalcd_fetch_ctrl.sv
// Framebuffer fetch scheduler: issues frame-aligned burst reads that keep the
// pixel line FIFO filled, throttled on FIFO free space.
module vgalcd_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_BYTES = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int LVL_WIDTH  = 10,
  parameter int VB_WIDTH   = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] fbba_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [VB_WIDTH-1:0]   line_beats_i,
  input  logic [VB_WIDTH-1:0]   vvlen_i,
  input  logic [LEN_WIDTH:0]    burst_beats_i,
  input  logic                  vend_i,
  input  logic [LVL_WIDTH:0]    fifo_free_i,
  vgalcd_fetch_ctrl_if.master   bus,
  output logic                  frame_start_o,
  output logic                  ovr_o,
  output logic                  busy_o
);

  localparam int CW0 = (VB_WIDTH > LEN_WIDTH + 1) ? VB_WIDTH : LEN_WIDTH + 1;
  localparam int CW  = (CW0 > LVL_WIDTH + 1) ? CW0 : LVL_WIDTH + 1;
  localparam int BSH = $clog2(BEAT_BYTES);
  localparam logic [LEN_WIDTH:0] BURST_ONE = 1;

  typedef enum logic [2:0] {IDLE, WAIT_V, CHECK, REQ, DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] fbba_s, stride_s, line_addr;
  logic [VB_WIDTH-1:0]   line_beats_s, vvlen_s, line, beat;
  logic [LEN_WIDTH:0]    burst_s;
  logic [CW-1:0]         len_r;
  logic                  ovr_pend, stop_pend;

  logic [CW-1:0] remain, burst_ext, len_c, beat_sum;
  logic          frame_done, fits, line_end;
  logic          do_latch, do_ovr, do_issue, do_hs;

  always_comb begin
    remain     = CW'(line_beats_s) - CW'(beat);
    burst_ext  = CW'(burst_s);
    len_c      = (burst_ext < remain) ? burst_ext : remain;
    fits       = CW'(fifo_free_i) >= len_c;
    frame_done = (line == vvlen_s) || (line_beats_s == '0);
    beat_sum   = CW'(beat) + len_r;
    line_end   = beat_sum == CW'(line_beats_s);
  end

  always_comb begin
    state_nx = state;
    do_latch = 1'b0;
    do_ovr   = 1'b0;
    do_issue = 1'b0;
    do_hs    = 1'b0;
    unique case (state)
      IDLE: if (en_i) state_nx = WAIT_V;
      WAIT_V, DONE: begin
        if (!en_i) state_nx = IDLE;
        else if (vend_i) begin
          do_latch = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (!en_i) state_nx = IDLE;
        else if (vend_i) begin
          // a vend_i right after the last burst still counts as a clean frame
          do_latch = 1'b1;
          do_ovr   = !frame_done;
          state_nx = CHECK;
        end else if (frame_done) state_nx = DONE;
        else if (fits) begin
          do_issue = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        do_ovr = en_i && vend_i;
        if (bus.gnt_i) begin
          do_hs = 1'b1;
          if (stop_pend || !en_i) state_nx = IDLE;
          else if (ovr_pend || vend_i) begin
            do_latch = 1'b1;
            state_nx = CHECK;
          end else state_nx = CHECK;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      fbba_s         <= '0;
      stride_s       <= '0;
      line_beats_s   <= '0;
      vvlen_s        <= '0;
      burst_s        <= '0;
      line_addr      <= '0;
      line           <= '0;
      beat           <= '0;
      len_r          <= '0;
      ovr_pend       <= 1'b0;
      stop_pend      <= 1'b0;
      bus.req_o      <= 1'b0;
      bus.req_addr_o <= '0;
      bus.req_len_o  <= '0;
      frame_start_o  <= 1'b0;
      ovr_o          <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state         <= state_nx;
      frame_start_o <= do_latch;
      ovr_o         <= do_ovr;
      busy_o        <= state_nx != IDLE;
      ovr_pend      <= (state == REQ) && !bus.gnt_i && (ovr_pend || (en_i && vend_i));
      stop_pend     <= (state == REQ) && !bus.gnt_i && (stop_pend || !en_i);

      if (do_issue) begin
        bus.req_o      <= 1'b1;
        bus.req_addr_o <= line_addr + (ADDR_WIDTH'(beat) << BSH);
        bus.req_len_o  <= LEN_WIDTH'(len_c - CW'(1));
        len_r          <= len_c;
      end else if (do_hs) begin
        bus.req_o <= 1'b0;
      end

      // a restart supersedes the counter update of a just-completed burst
      if (do_latch) begin
        fbba_s       <= fbba_i;
        stride_s     <= stride_i;
        line_beats_s <= line_beats_i;
        vvlen_s      <= vvlen_i;
        burst_s      <= (burst_beats_i == '0) ? BURST_ONE : burst_beats_i;
        line_addr    <= fbba_i;
        line         <= '0;
        beat         <= '0;
      end else if (do_hs) begin
        if (line_end) begin
          beat      <= '0;
          line      <= line + VB_WIDTH'(1);
          line_addr <= line_addr + stride_s;
        end else begin
          beat <= VB_WIDTH'(beat_sum);
        end
      end
    end
  end

endmodule

// File: tb/tb_vgalcd_fetch_ctrl.sv
// Scoreboard bench for vgalcd_fetch_ctrl: expected bursts are queued with the
// stimulus and compared against every cycle the request port is valid.
module tb_vgalcd_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] fbba = '0;
  logic [31:0] stride = '0;
  logic [11:0] line_beats = '0;
  logic [11:0] vvlen = '0;
  logic [8:0]  burst = '0;
  logic        vend = 1'b0;
  logic [10:0] free = 11'd64;
  logic        frame_start, ovr, busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fs_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;
  exp_t exp_q[$];

  vgalcd_fetch_ctrl_if #(.ADDR_WIDTH(32), .LEN_WIDTH(8)) bif ();

  vgalcd_fetch_ctrl #(
    .ADDR_WIDTH(32), .BEAT_BYTES(4), .LEN_WIDTH(8), .LVL_WIDTH(10), .VB_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .fbba_i(fbba), .stride_i(stride),
    .line_beats_i(line_beats), .vvlen_i(vvlen), .burst_beats_i(burst),
    .vend_i(vend), .fifo_free_i(free), .bus(bif),
    .frame_start_o(frame_start), .ovr_o(ovr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l);
    exp_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // Reference burst sequence for one full frame.
  task automatic push_frame(input logic [31:0] base, input logic [31:0] strd,
                            input int lb, input int bb, input int lines);
    for (int l = 0; l < lines; l++) begin
      int b = 0;
      while (b < lb) begin
        int n = (bb < lb - b) ? bb : lb - b;
        push(base + 32'(l) * strd + 32'(b * 4), 8'(n - 1));
        b += n;
      end
    end
  endtask

  task automatic pulse_vend();
    vend = 1'b1;
    tick();
    vend = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bif.req_o && n < budget) begin
      tick();
      n++;
    end
    check("req_wait", 64'(bif.req_o), 64'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("q_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_cfg(input logic [31:0] a, input logic [31:0] s, input int lb,
                         input int bb, input int vl);
    fbba = a;
    stride = s;
    line_beats = 12'(lb);
    burst = 9'(bb);
    vvlen = 12'(vl);
  endtask

  // Every valid cycle must match the head of the queue, which also covers hold.
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (ovr) ovr_cnt++;
    if (rst_n && bif.req_o) begin
      if (exp_q.size() == 0) check("unexpected_req", 64'(bif.req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        check("req_addr", 64'(bif.req_addr_o), 64'(exp_q[0].addr));
        check("req_len", 64'(bif.req_len_o), 64'(exp_q[0].len));
        if (bif.gnt_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int fs0, ovr0;
    bif.gnt_i = 1'b1;
    repeat (3) tick();
    check("rst_req", 64'(bif.req_o), 64'd0);
    check("rst_addr", 64'(bif.req_addr_o), 64'd0);
    check("rst_len", 64'(bif.req_len_o), 64'd0);
    check("rst_fs", 64'(frame_start), 64'd0);
    check("rst_ovr", 64'(ovr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Basic frame
    set_cfg(32'h1000, 32'h200, 10, 4, 2);
    en = 1'b1;
    tick();
    tick();
    check("busy_wait_v", 64'(busy), 64'd1);
    push(32'h1000, 8'd3); push(32'h1010, 8'd3); push(32'h1020, 8'd1);
    push(32'h1200, 8'd3); push(32'h1210, 8'd3); push(32'h1220, 8'd1);
    fs0 = fs_cnt;
    pulse_vend();
    check("fs_n1", 64'(frame_start), 64'd1);
    check("req_n1", 64'(bif.req_o), 64'd0);
    tick();
    check("req_n2", 64'(bif.req_o), 64'd1);
    tick();
    check("req_gap", 64'(bif.req_o), 64'd0);
    tick();
    check("req_next", 64'(bif.req_o), 64'd1);
    wait_empty(100);
    repeat (5) tick();
    check("done_req", 64'(bif.req_o), 64'd0);
    check("done_busy", 64'(busy), 64'd1);
    check("fs_count", 64'(fs_cnt - fs0), 64'd1);

    // FIFO throttle
    set_cfg(32'h4000, 32'h100, 10, 4, 1);
    free = 11'd2;
    pulse_vend();
    repeat (5) tick();
    check("throttle_req", 64'(bif.req_o), 64'd0);
    push_frame(32'h4000, 32'h100, 10, 4, 1);
    free = 11'd4;
    tick();
    check("throttle_release", 64'(bif.req_o), 64'd1);
    check("throttle_len", 64'(bif.req_len_o), 64'd3);
    free = 11'd64;
    wait_empty(100);

    // Handshake hold with config churn
    set_cfg(32'h8000, 32'h100, 8, 8, 2);
    bif.gnt_i = 1'b0;
    push_frame(32'h8000, 32'h100, 8, 8, 2);
    pulse_vend();
    wait_req(10);
    for (int i = 0; i < 5; i++) begin
      set_cfg(32'hDEAD_0000 + 32'(i), 32'h1, 3, 1, 9);
      tick();
    end
    check("hold_req", 64'(bif.req_o), 64'd1);
    bif.gnt_i = 1'b1;
    wait_empty(100);
    repeat (3) tick();

    // Overrun while a request is pending
    set_cfg(32'hA000, 32'h40, 4, 4, 4);
    bif.gnt_i = 1'b0;
    push(32'hA000, 8'd3);
    ovr0 = ovr_cnt;
    pulse_vend();
    wait_req(10);
    repeat (2) tick();
    fbba = 32'hB000;
    pulse_vend();
    check("ovr_pulse", 64'(ovr), 64'd1);
    tick();
    check("ovr_once", 64'(ovr), 64'd0);
    check("ovr_req_held", 64'(bif.req_o), 64'd1);
    push_frame(32'hB000, 32'h40, 4, 4, 4);
    bif.gnt_i = 1'b1;
    tick();
    check("ovr_fs", 64'(frame_start), 64'd1);
    wait_empty(100);
    repeat (3) tick();
    check("ovr_count", 64'(ovr_cnt - ovr0), 64'd1);

    // Disable during REQ
    set_cfg(32'hC000, 32'h40, 4, 4, 2);
    bif.gnt_i = 1'b0;
    push(32'hC000, 8'd3);
    pulse_vend();
    wait_req(10);
    en = 1'b0;
    tick();
    check("dis_req_held", 64'(bif.req_o), 64'd1);
    check("dis_busy_held", 64'(busy), 64'd1);
    bif.gnt_i = 1'b1;
    tick();
    check("dis_req", 64'(bif.req_o), 64'd0);
    check("dis_busy", 64'(busy), 64'd0);
    repeat (5) tick();
    check("dis_idle", 64'(busy), 64'd0);
    check("dis_q", 64'(exp_q.size()), 64'd0);

    // Zero line_beats
    set_cfg(32'hD000, 32'h40, 0, 4, 2);
    en = 1'b1;
    tick();
    pulse_vend();
    check("zero_fs", 64'(frame_start), 64'd1);
    repeat (5) tick();
    check("zero_req", 64'(bif.req_o), 64'd0);
    check("zero_busy", 64'(busy), 64'd1);

    // Reset while a request is pending
    set_cfg(32'hE000, 32'h40, 4, 4, 1);
    bif.gnt_i = 1'b0;
    push(32'hE000, 8'd3);
    pulse_vend();
    wait_req(10);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    check("mrst_req", 64'(bif.req_o), 64'd0);
    check("mrst_addr", 64'(bif.req_addr_o), 64'd0);
    check("mrst_len", 64'(bif.req_len_o), 64'd0);
    check("mrst_fs", 64'(frame_start), 64'd0);
    check("mrst_ovr", 64'(ovr), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    bif.gnt_i = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
